// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared FSM state encoding, ALU flag bit indices and opcodes
// for the ALU sequencing arbiter.
package alu_seq_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR     = 3'd1,
    SEND_A  = 3'd2,
    SEND_B  = 3'd3,
    SEND_OP = 3'd4,
    WAIT    = 3'd5,
    RESP    = 3'd6
  } state_t;
  localparam int FLAG_DONE  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_SIGN  = 3;
  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] AND  = 4'd2;
  localparam logic [3:0] OR   = 4'd3;
  localparam logic [3:0] NOT  = 4'd4;
  localparam logic [3:0] NAND = 4'd5;
  localparam logic [3:0] NOR  = 4'd6;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after rr_ptr+1;
// the pointer itself lives in the parent.
module rr_arbiter
  import alu_seq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id
);
  // Scanning farthest-to-nearest lets the nearest set bit win the last assignment.
  always_comb begin
    grant = '0;
    id = '0;
    for (int p = 0; p < NREQ; p++)
      if (int'(rr_ptr) == p)
        for (int k = NREQ; k >= 1; k--)
          if (req[(p + k) % NREQ]) begin
            grant = '0;
            grant[(p + k) % NREQ] = 1'b1;
            id = IDW'((p + k) % NREQ);
          end
  end
endmodule

// File: rtl/alu_seq_arbiter.sv
// alu_seq_arbiter: shares one nibble-serial ALU between NREQ requesters, round-robin.
// Optional ALU_SEQ_TIMEOUT_EN aborts a WAIT that never sees done after TIMEOUT cycles.
module alu_seq_arbiter
  import alu_seq_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0] req_op,
  output logic [NREQ-1:0]   gnt,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [3:0]        resp_result,
  output logic [3:0]        resp_flags,
  output logic              resp_err,
  output logic              alu_reset,
  output logic [3:0]        alu_data,
  input  logic [3:0]        alu_result,
  input  logic [3:0]        alu_flags
);
  state_t state;
  logic [IDW-1:0] rr_ptr, id_q, win_id;
  logic [NREQ-1:0] win;
  logic [3:0] a_q, b_q, op_q, a_sel, b_sel, op_sel;
  if (NREQ < 2 || NREQ > 4 || IDW != ((NREQ > 2) ? 2 : 1) || TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_cfg
    $error("alu_seq_arbiter: unsupported NREQ/IDW/TIMEOUT combination");
  end
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req(req),
    .rr_ptr(rr_ptr),
    .grant(win),
    .id(win_id)
  );
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    op_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (win[i]) begin
        a_sel = req_a[4*i +: 4];
        b_sel = req_b[4*i +: 4];
        op_sel = req_op[4*i +: 4];
      end
  end
`ifdef ALU_SEQ_TIMEOUT_EN
  logic [3:0] wait_cnt;
`else
  assign resp_err = 1'b0;
`endif
  // Every output is assigned on the transition into the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      gnt <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_result <= '0;
      resp_flags <= '0;
      alu_reset <= 1'b1;
      alu_data <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      resp_err <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
      gnt <= '0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          alu_reset <= 1'b1;
          if (|req) begin
            gnt <= win;
            id_q <= win_id;
            a_q <= a_sel;
            b_q <= b_sel;
            op_q <= op_sel;
            state <= CLR;
          end
        end
        CLR: begin
          alu_reset <= 1'b0;
          alu_data <= a_q;
          state <= SEND_A;
        end
        SEND_A: begin
          alu_data <= b_q;
          state <= SEND_B;
        end
        SEND_B: begin
          alu_data <= op_q;
          state <= SEND_OP;
        end
        SEND_OP: begin
`ifdef ALU_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (alu_flags[FLAG_DONE]) begin
            resp_valid <= 1'b1;
            resp_id <= id_q;
            resp_result <= alu_result;
            resp_flags <= alu_flags;
            alu_reset <= 1'b1;
            state <= RESP;
`ifdef ALU_SEQ_TIMEOUT_EN
            resp_err <= 1'b0;
          end else if (wait_cnt == 4'(TIMEOUT)) begin
            resp_valid <= 1'b1;
            resp_id <= id_q;
            resp_result <= '0;
            resp_flags <= '0;
            resp_err <= 1'b1;
            alu_reset <= 1'b1;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
`endif
          end
        end
        RESP: begin
          rr_ptr <= id_q;
          alu_reset <= 1'b1;
          state <= IDLE;
        end
        default: begin
          alu_reset <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
